// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Purpose  : Shared definitions for the round-robin mux arbiter: default
//            sizing constants, output-stage state encoding and a modulo-N
//            index increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

  localparam int unsigned C_N_REQ_DEFAULT = 4;
  localparam int unsigned C_WIDTH_DEFAULT = 8;

  // Output stage occupancy; the FULL state is exactly out_valid.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Modulo-n increment; never produces a value >= n.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_mux_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin priority picker. Scans requesters
//            starting just after last_grant, wrapping, with last_grant itself
//            as the final candidate.
// Ports    : req_valid  [N_REQ]   - per-requester valid
//            last_grant [IDX_W]   - index granted most recently
//            any_valid            - at least one requester is valid
//            winner     [IDX_W]   - chosen requester (0 when none valid)
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = C_N_REQ_DEFAULT,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    w_cand    = last_grant;
    // N_REQ steps visit every index exactly once, ending on last_grant.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = IDX_W'(next_idx(32'(w_cand), N_REQ));
      if (!any_valid && req_valid[w_cand]) begin
        any_valid = 1'b1;
        winner    = w_cand;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Round-robin arbiter sharing one N-to-1 payload mux among N_REQ
//            valid/ready requesters, feeding a one-entry registered output.
//            One transfer per clock, one cycle latency.
// Ports    : clk, rst (async, active-low)
//            req_valid [N_REQ], req_data [N_REQ*WIDTH], req_ready [N_REQ]
//            out_valid, out_data [WIDTH], out_ready
//            grant_idx [clog2(N_REQ)] - source of the data in out_data
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = C_N_REQ_DEFAULT,
  parameter int unsigned WIDTH = C_WIDTH_DEFAULT,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       grant_idx
);

  localparam logic [IDX_W-1:0] C_LAST_RESET = IDX_W'(N_REQ - 1);

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic [IDX_W-1:0] grant_idx_q,  grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             w_load_en;
  logic             w_any_valid;
  logic [IDX_W-1:0] w_winner;
  logic [WIDTH-1:0] w_payload [N_REQ];

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .any_valid  (w_any_valid),
    .winner     (w_winner)
  );

  // Register can accept when empty or being drained this cycle.
  assign w_load_en = (state_q == ST_EMPTY) || out_ready;

  // Unpack the flat payload bus so the mux is a simple array index.
  // req_ready is gated by rst so nothing is accepted while in reset.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign w_payload[i] = req_data[i*WIDTH +: WIDTH];
    assign req_ready[i] = rst && w_load_en && w_any_valid
                          && (w_winner == IDX_W'(i));
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    if (w_load_en) begin
      if (w_any_valid) begin
        state_d      = ST_FULL;
        out_data_d   = w_payload[w_winner];
        grant_idx_d  = w_winner;
        last_grant_d = w_winner;
      end else begin
        // Drained with nothing to replace it: data/index hold, pointer kept.
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= C_LAST_RESET;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign grant_idx = grant_idx_q;

endmodule : rr_mux_arbiter
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed self-checking bench for rr_mux_arbiter (N_REQ=4,
//            WIDTH=8) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  grant_idx;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(
    .N_REQ (4),
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] g);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".grant"}, 32'(grant_idx), 32'(g));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b1;

    // Reset held with all requesters valid.
    #1 rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("reset_hold.ready", 32'(req_ready), 32'h0);
    chk_out("reset_hold", 1'b0, 8'h00, 2'd0);

    // Release: requester 0 has top priority.
    rst = 1'b1;
    #1;
    chk("release.ready", 32'(req_ready), 32'b0001);

    // Full contention: 0,1,2,3,0,1 with no bubbles.
    tick();
    chk_out("cont0", 1'b1, 8'h10, 2'd0);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk_out($sformatf("cont%0d", k), 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    end

    // Backpressure with grant 1 loaded.
    out_ready = 1'b0;
    #1;
    chk("bp.ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 8'h11, 2'd1);
      chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("bp_rel", 1'b1, 8'h12, 2'd2);

    // Lone requester 2 (also the last grant) is granted again.
    req_valid = 4'b0100;
    req_data[2*8 +: 8] = 8'hA5;
    #1;
    chk("single.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // Sparse with wrap: get last grant to 3, then 1010 -> 1.
    req_valid = 4'b1000;
    #1;
    chk("sp3.ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("sp3", 1'b1, 8'h13, 2'd3);
    req_valid = 4'b1010;
    #1;
    chk("sp_wrap.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("sp_wrap", 1'b1, 8'h11, 2'd1);
    req_valid = 4'b0010;
    #1;
    chk("sp_lone.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("sp_lone", 1'b1, 8'h11, 2'd1);
    req_valid = 4'b0000;
    #1;
    chk("idle.ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("idle", 1'b0, 8'h11, 2'd1);
    tick();
    chk_out("idle2", 1'b0, 8'h11, 2'd1);

    // Pointer survived the idle period: last=1, so 1111 -> 2, then 3.
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    #1;
    chk("resume.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("resume0", 1'b1, 8'h12, 2'd2);
    tick();
    chk_out("resume1", 1'b1, 8'h13, 2'd3);

    // Reset mid-stream, between edges.
    #3 rst = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    chk("midrst.ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_rel.ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("midrst_rel", 1'b1, 8'h10, 2'd0);
    tick();
    chk_out("midrst_next", 1'b1, 8'h11, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
`default_nettype wire

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N-to-1 mux datapath among N_REQ valid/ready requesters.
- Selects one requester per accepted transfer and steers its payload through the mux into a registered output stage.
- Sits between several producer blocks and a single consumer.
- Throughput is one transfer per clock; latency is one cycle.

Parameters:
- N_REQ, 4: number of requesters (>=2).
- WIDTH, 8: payload width in bits.

Ports:
- clk  input  1: clock; all state updates on rising edge.
- rst  input  1: reset, asynchronous, active-low.
- req_valid  input  N_REQ: per-requester valid.
- req_data  input  N_REQ*WIDTH: packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ: per-requester accept, one-hot or zero.
- out_valid  output  1: output register holds valid data.
- out_data  output  WIDTH: registered payload of the last winner.
- out_ready  input  1: consumer accepts out_data this cycle.
- grant_idx  output  $clog2(N_REQ): index of the requester whose data is in out_data.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, grant_idx=0, last_grant=N_REQ-1. Requester 0 therefore has top priority after reset.
- Two states, encoded by out_valid:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load_en = !out_valid || out_ready. This is combinational: the output register can take new data when it is empty or being drained this cycle.
- Winner selection (combinational):
  - Scan indices (last_grant+1) mod N_REQ, +2, ..., wrapping; the first i with req_valid[i]=1 wins.
  - The scan includes last_grant itself as the final candidate. A lone requester is granted every cycle.
- req_ready[i] = load_en && any_valid && (winner==i). At most one bit is set. req_ready never asserts for a requester with req_valid=0.
- Transfer from requester i occurs on a cycle where req_valid[i] && req_ready[i]. On the next edge:
  - out_data <= req_data[i], out_valid <= 1
  - grant_idx <= i, last_grant <= i
- If load_en && !any_valid: out_valid <= 0. out_data and grant_idx hold their values; last_grant is unchanged.
- If !load_en (FULL and out_ready=0): all registers hold; req_ready=0.
- Simultaneous drain and load (FULL, out_ready=1, some req_valid): the new winner is loaded in the same cycle. out_valid stays 1, with no bubble.
- out_valid/out_data/grant_idx must stay stable while out_valid=1 and out_ready=0.
- Requester side: a requester may deassert req_valid without a grant. The arbiter keeps no per-requester state beyond last_grant.
- Reset mid-operation:
  - Any in-flight output is discarded immediately: out_valid drops asynchronously.
  - The pointer returns to N_REQ-1.
  - req_ready is 0 while rst=0.
- last_grant wraps from N_REQ-1 to 0. For non-power-of-two N_REQ, indices >= N_REQ are never produced.

Decomposition:
- Package rr_arb_pkg holds:
  - a function next_idx(idx, n) for modulo-N increment;
  - the default N_REQ and WIDTH constants.
- Sub-module rr_picker: purely combinational round-robin priority picker.
  - Inputs: req_valid, last_grant.
  - Outputs: any_valid, winner index.
- The payload mux and output register stay in rr_mux_arbiter.

Test Plan:
- Reset: hold rst=0 with req_valid=4'b1111 -> out_valid=0, out_data=0, grant_idx=0, req_ready=4'b0000. Release rst, out_ready=1 -> next edge out_valid=1, grant_idx=0.
- Single requester: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 -> req_ready=4'b0100 the same cycle. Next edge: out_valid=1, out_data=8'hA5, grant_idx=2.
- Full contention: req_valid=4'b1111, data i=8'h10+i, out_ready=1 for 6 cycles -> grant_idx sequence 0,1,2,3,0,1 and out_data 10,11,12,13,10,11, with out_valid continuously 1.
- Backpressure: after grant_idx=1 is loaded, out_ready=0 for 3 cycles with all valid -> req_ready=0 and out_data held constant. Set out_ready=1 -> next load grant_idx=2.
- Sparse with wrap: last grant=3, req_valid=4'b1010 -> winner 1. Then req_valid=4'b0010 only -> winner 1 again. Then no valid with out_ready=1 -> out_valid=0.
- Reset mid-stream: during full contention, assert rst=0 between edges -> out_valid falls before the next edge. After release, first grant_idx=0.
